// File: rtl/swivm_muldiv_if.sv
// rtl/swivm_muldiv_if.sv - launch/result bundle between the EXEC stage and the mul/div unit
interface swivm_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic             i_signed;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;
  logic             o_divzero;

  modport master (
    output i_start, i_op, i_signed, i_a, i_b,
    input  o_busy, o_done, o_result, o_divzero
  );

  modport slave (
    input  i_start, i_op, i_signed, i_a, i_b,
    output o_busy, o_done, o_result, o_divzero
  );
endinterface

// File: rtl/swivm_muldiv.sv
// rtl/swivm_muldiv.sv - iterative shift-add multiplier / restoring divider, WIDTH+2 cycle fixed latency
module swivm_muldiv #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input logic          i_clk,
  input logic          i_reset,
  swivm_muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             is_div_q;
  logic             bzero_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] acc;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             divzero_q;

  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             launch_div;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    bus.o_busy = 1'b0;
    case (state)
      IDLE: if (bus.i_start) state_nx = RUN;
      RUN: begin
        bus.o_busy = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_nx = FINISH;
      end
      FINISH: begin
        bus.o_busy = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // x carries the dividend in and the quotient out; acc is the partial remainder,
  // shifted with one extra bit so a full-range divisor never truncates.
  assign rem_sh     = {acc, x[WIDTH-1]};
  assign ge         = rem_sh >= {1'b0, y};
  assign q_fix      = qneg_q ? -x : x;
  assign r_fix      = rneg_q ? -acc : acc;
  assign launch_div = (bus.i_op == OP_DIV) || (bus.i_op == OP_MOD);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt       <= '0;
      op_q      <= '0;
      is_div_q  <= 1'b0;
      bzero_q   <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      a_q       <= '0;
      x         <= '0;
      y         <= '0;
      acc       <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      divzero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.i_start) begin
          op_q     <= bus.i_op;
          is_div_q <= launch_div;
          bzero_q  <= (bus.i_b == '0);
          a_q      <= bus.i_a;
          cnt      <= '0;
          acc      <= '0;
          qneg_q   <= bus.i_signed && (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
          rneg_q   <= bus.i_signed && bus.i_a[WIDTH-1];
          if (launch_div) begin
            x <= mag(bus.i_a, bus.i_signed);
            y <= mag(bus.i_b, bus.i_signed);
          end else begin
            x <= bus.i_a;
            y <= bus.i_b;
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div_q) begin
            acc <= ge ? WIDTH'(rem_sh - {1'b0, y}) : rem_sh[WIDTH-1:0];
            x   <= {x[WIDTH-2:0], ge};
          end else begin
            acc <= acc + (y[0] ? x : '0);
            x   <= {x[WIDTH-2:0], 1'b0};
            y   <= {1'b0, y[WIDTH-1:1]};
          end
        end
        FINISH: begin
          done_q <= 1'b1;
          if (is_div_q) begin
            divzero_q <= bzero_q;
            if (bzero_q) result_q <= (op_q == OP_DIV) ? '1 : a_q;
            else         result_q <= (op_q == OP_DIV) ? q_fix : r_fix;
          end else begin
            divzero_q <= 1'b0;
            result_q  <= acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_done    = done_q;
  assign bus.o_result  = result_q;
  assign bus.o_divzero = divzero_q;
endmodule
